// File: rtl/juego_pkg.sv
// Shared types and constants for the Battleship turn sequencer.
package juego_pkg;

  typedef enum logic [2:0] {
    SELECCION = 3'd0,
    COLOC_J   = 3'd1,
    COLOC_PC  = 3'd2,
    TURNO_J   = 3'd3,
    ESPERA_J  = 3'd4,
    TURNO_PC  = 3'd5,
    FIN       = 3'd6
  } estado_t;

  localparam logic [1:0] GANADOR_NINGUNO = 2'b00;
  localparam logic [1:0] GANADOR_JUGADOR = 2'b01;
  localparam logic [1:0] GANADOR_PC      = 2'b10;

  localparam int MAX_SHIPS_DEF = 5;

  // Ship counters saturate at zero instead of wrapping.
  function automatic logic [2:0] decrementar_sat(input logic [2:0] valor, input logic en);
    if (en && valor != 3'd0) begin
      return valor - 3'd1;
    end
    return valor;
  endfunction

endpackage

// File: rtl/temporizador_turno.sv
// Player turn timer: one-second prescaler feeding a saturating seconds down-counter.
module temporizador_turno #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TURN_SECONDS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cargar,
  input  logic       habilitar,
  output logic [3:0] segundos,
  output logic       expirado
);

  localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [3:0]      SEG_INI   = 4'(TURN_SECONDS);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    seg_q, seg_d;

  always_comb begin
    presc_d = presc_q;
    seg_d   = seg_q;
    if (cargar) begin
      presc_d = '0;
      seg_d   = SEG_INI;
    end else if (habilitar) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (seg_q != 4'd0) begin
          seg_d = seg_q - 4'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      seg_q   <= SEG_INI;
    end else begin
      presc_q <= presc_d;
      seg_q   <= seg_d;
    end
  end

  assign segundos = seg_q;
  assign expirado = (seg_q == 4'd0);

endmodule

// File: rtl/controlador_turnos.sv
// Battleship game sequencer: selection, placement, alternating shots and winner detection.
module controlador_turnos
  import juego_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TURN_SECONDS = 15,
  parameter int MAX_SHIPS    = MAX_SHIPS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       seleccionListo,
  input  logic [2:0] cantidadBarcosSeleccionada,
  input  logic       colocacionListaJugador,
  input  logic       colocacionListaPC,
  input  logic       disparoJugador,
  input  logic       resultadoJugador,
  input  logic       hundioJugador,
  input  logic       resultadoPC,
  input  logic       hundioPC,
  output logic [2:0] estado,
  output logic       habilitarSeleccion,
  output logic       habilitarColocacion,
  output logic       turnoJugador,
  output logic       solicitarDisparoPC,
  output logic       disparoAutomatico,
  output logic [3:0] segundosRestantes,
  output logic [2:0] barcosPCRestantes,
  output logic [2:0] barcosJugadorRestantes,
  output logic [1:0] ganador,
  output logic       juegoTerminado
);

  estado_t    estado_q, estado_d;
  logic [2:0] barcos_pc_q, barcos_pc_d;
  logic [2:0] barcos_j_q, barcos_j_d;
  logic [1:0] ganador_q, ganador_d;
  logic       solicitar_q, solicitar_d;
  logic       automatico_q, automatico_d;
  logic       cargar_timer;
  logic       expirado;
  logic [3:0] segundos;
  logic [2:0] pc_tras_disparo;
  logic [2:0] j_tras_disparo;

  temporizador_turno #(
    .CLK_HZ       (CLK_HZ),
    .TURN_SECONDS (TURN_SECONDS)
  ) u_temporizador (
    .clk       (clk),
    .reset     (reset),
    .cargar    (cargar_timer),
    .habilitar (estado_q == TURNO_J),
    .segundos  (segundos),
    .expirado  (expirado)
  );

  assign pc_tras_disparo = decrementar_sat(barcos_pc_q, hundioJugador);
  assign j_tras_disparo  = decrementar_sat(barcos_j_q, hundioPC);

  always_comb begin
    estado_d     = estado_q;
    barcos_pc_d  = barcos_pc_q;
    barcos_j_d   = barcos_j_q;
    ganador_d    = ganador_q;
    solicitar_d  = 1'b0;
    automatico_d = 1'b0;
    cargar_timer = 1'b0;
    case (estado_q)
      SELECCION: begin
        if (seleccionListo && cantidadBarcosSeleccionada != 3'd0 &&
            int'(cantidadBarcosSeleccionada) <= MAX_SHIPS) begin
          barcos_pc_d = cantidadBarcosSeleccionada;
          barcos_j_d  = cantidadBarcosSeleccionada;
          estado_d    = COLOC_J;
        end
      end
      COLOC_J: begin
        if (colocacionListaJugador) estado_d = COLOC_PC;
      end
      COLOC_PC: begin
        if (colocacionListaPC) begin
          estado_d     = TURNO_J;
          cargar_timer = 1'b1;
        end
      end
      TURNO_J: begin
        // A real shot on the expiry cycle takes precedence over the automatic one.
        if (disparoJugador) begin
          estado_d = ESPERA_J;
        end else if (expirado) begin
          automatico_d = 1'b1;
          estado_d     = ESPERA_J;
        end
      end
      ESPERA_J: begin
        if (resultadoJugador) begin
          barcos_pc_d = pc_tras_disparo;
          if (pc_tras_disparo == 3'd0) begin
            ganador_d = GANADOR_JUGADOR;
            estado_d  = FIN;
          end else begin
            solicitar_d = 1'b1;
            estado_d    = TURNO_PC;
          end
        end
      end
      TURNO_PC: begin
        if (resultadoPC) begin
          barcos_j_d = j_tras_disparo;
          if (j_tras_disparo == 3'd0) begin
            ganador_d = GANADOR_PC;
            estado_d  = FIN;
          end else begin
            cargar_timer = 1'b1;
            estado_d     = TURNO_J;
          end
        end
      end
      FIN: begin
        estado_d = FIN;
      end
      default: estado_d = SELECCION;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q     <= SELECCION;
      barcos_pc_q  <= 3'd0;
      barcos_j_q   <= 3'd0;
      ganador_q    <= GANADOR_NINGUNO;
      solicitar_q  <= 1'b0;
      automatico_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      barcos_pc_q  <= barcos_pc_d;
      barcos_j_q   <= barcos_j_d;
      ganador_q    <= ganador_d;
      solicitar_q  <= solicitar_d;
      automatico_q <= automatico_d;
    end
  end

  assign estado                 = estado_q;
  assign habilitarSeleccion     = (estado_q == SELECCION);
  assign habilitarColocacion    = (estado_q == COLOC_J);
  assign turnoJugador           = (estado_q == TURNO_J);
  assign juegoTerminado         = (estado_q == FIN);
  assign solicitarDisparoPC     = solicitar_q;
  assign disparoAutomatico      = automatico_q;
  assign segundosRestantes      = segundos;
  assign barcosPCRestantes      = barcos_pc_q;
  assign barcosJugadorRestantes = barcos_j_q;
  assign ganador                = ganador_q;

endmodule

// File: tb/tb_controlador_turnos.sv
// Directed bench for controlador_turnos with a fast 4-cycle second and 2-second turns.
module tb_controlador_turnos;

  logic       clk = 1'b0;
  logic       reset;
  logic       seleccionListo;
  logic [2:0] cantidadBarcosSeleccionada;
  logic       colocacionListaJugador;
  logic       colocacionListaPC;
  logic       disparoJugador;
  logic       resultadoJugador;
  logic       hundioJugador;
  logic       resultadoPC;
  logic       hundioPC;
  logic [2:0] estado;
  logic       habilitarSeleccion;
  logic       habilitarColocacion;
  logic       turnoJugador;
  logic       solicitarDisparoPC;
  logic       disparoAutomatico;
  logic [3:0] segundosRestantes;
  logic [2:0] barcosPCRestantes;
  logic [2:0] barcosJugadorRestantes;
  logic [1:0] ganador;
  logic       juegoTerminado;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  controlador_turnos #(
    .CLK_HZ       (4),
    .TURN_SECONDS (2),
    .MAX_SHIPS    (5)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .seleccionListo             (seleccionListo),
    .cantidadBarcosSeleccionada (cantidadBarcosSeleccionada),
    .colocacionListaJugador     (colocacionListaJugador),
    .colocacionListaPC          (colocacionListaPC),
    .disparoJugador             (disparoJugador),
    .resultadoJugador           (resultadoJugador),
    .hundioJugador              (hundioJugador),
    .resultadoPC                (resultadoPC),
    .hundioPC                   (hundioPC),
    .estado                     (estado),
    .habilitarSeleccion         (habilitarSeleccion),
    .habilitarColocacion        (habilitarColocacion),
    .turnoJugador               (turnoJugador),
    .solicitarDisparoPC         (solicitarDisparoPC),
    .disparoAutomatico          (disparoAutomatico),
    .segundosRestantes          (segundosRestantes),
    .barcosPCRestantes          (barcosPCRestantes),
    .barcosJugadorRestantes     (barcosJugadorRestantes),
    .ganador                    (ganador),
    .juegoTerminado             (juegoTerminado)
  );

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_pulses();
    seleccionListo         = 1'b0;
    colocacionListaJugador = 1'b0;
    colocacionListaPC      = 1'b0;
    disparoJugador         = 1'b0;
    resultadoJugador       = 1'b0;
    hundioJugador          = 1'b0;
    resultadoPC            = 1'b0;
    hundioPC               = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_tick();
    tick();
    clear_pulses();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cantidadBarcosSeleccionada = 3'd0;
    clear_pulses();
    ticks(2);
    chk("rst_estado", 32'(estado), 0);
    chk("rst_segundos", 32'(segundosRestantes), 2);
    chk("rst_barcos_pc", 32'(barcosPCRestantes), 0);
    chk("rst_barcos_j", 32'(barcosJugadorRestantes), 0);
    chk("rst_ganador", 32'(ganador), 0);
    chk("rst_hab_sel", 32'(habilitarSeleccion), 1);
    chk("rst_pulsos", 32'({solicitarDisparoPC, disparoAutomatico, juegoTerminado}), 0);
    reset = 1'b0;

    seleccionListo = 1'b1; cantidadBarcosSeleccionada = 3'd0;
    tick();
    chk("sel_cnt0", 32'(estado), 0);
    cantidadBarcosSeleccionada = 3'd6;
    tick();
    chk("sel_cnt6", 32'(estado), 0);
    chk("sel_cnt6_barcos", 32'(barcosPCRestantes), 0);
    cantidadBarcosSeleccionada = 3'd3;
    pulse_tick();
    chk("sel_cnt3", 32'(estado), 1);
    chk("sel_barcos_pc", 32'(barcosPCRestantes), 3);
    chk("sel_barcos_j", 32'(barcosJugadorRestantes), 3);
    chk("hab_coloc", 32'(habilitarColocacion), 1);

    resultadoPC = 1'b1; hundioPC = 1'b1; disparoJugador = 1'b1;
    pulse_tick();
    chk("stray_estado", 32'(estado), 1);
    chk("stray_barcos_j", 32'(barcosJugadorRestantes), 3);

    colocacionListaJugador = 1'b1;
    pulse_tick();
    chk("coloc_pc", 32'(estado), 2);
    colocacionListaPC = 1'b1;
    pulse_tick();
    chk("turno_j", 32'(estado), 3);
    chk("turno_j_seg", 32'(segundosRestantes), 2);
    chk("turno_j_flag", 32'(turnoJugador), 1);

    // Timeout without a shot: seconds fall every 4 cycles, then one auto pulse.
    ticks(3);
    chk("seg_c3", 32'(segundosRestantes), 2);
    tick();
    chk("seg_c4", 32'(segundosRestantes), 1);
    ticks(4);
    chk("seg_c8", 32'(segundosRestantes), 0);
    chk("seg_c8_estado", 32'(estado), 3);
    chk("seg_c8_auto", 32'(disparoAutomatico), 0);
    tick();
    chk("auto_pulso", 32'(disparoAutomatico), 1);
    chk("auto_estado", 32'(estado), 4);
    tick();
    chk("auto_fin_pulso", 32'(disparoAutomatico), 0);
    chk("auto_espera", 32'(estado), 4);

    resultadoJugador = 1'b1; hundioJugador = 1'b0;
    pulse_tick();
    chk("turno_pc", 32'(estado), 5);
    chk("sol_pc_pulso", 32'(solicitarDisparoPC), 1);
    chk("fallo_barcos_pc", 32'(barcosPCRestantes), 3);
    tick();
    chk("sol_pc_fin", 32'(solicitarDisparoPC), 0);
    resultadoPC = 1'b1; hundioPC = 1'b0;
    pulse_tick();
    chk("vuelta_turno_j", 32'(estado), 3);
    chk("recarga_seg", 32'(segundosRestantes), 2);
    chk("fallo_barcos_j", 32'(barcosJugadorRestantes), 3);

    // Player shot on the exact timeout cycle wins over the automatic shot.
    ticks(8);
    chk("exacto_seg0", 32'(segundosRestantes), 0);
    disparoJugador = 1'b1;
    pulse_tick();
    chk("exacto_estado", 32'(estado), 4);
    chk("exacto_auto", 32'(disparoAutomatico), 0);
    tick();
    chk("exacto_auto2", 32'(disparoAutomatico), 0);

    // One-ship game: player wins on the first hit.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_medio", 32'(estado), 0);
    seleccionListo = 1'b1; cantidadBarcosSeleccionada = 3'd1;
    pulse_tick();
    colocacionListaJugador = 1'b1;
    pulse_tick();
    colocacionListaPC = 1'b1;
    pulse_tick();
    disparoJugador = 1'b1;
    pulse_tick();
    chk("g1_espera", 32'(estado), 4);
    resultadoJugador = 1'b1; hundioJugador = 1'b1;
    pulse_tick();
    chk("g1_fin", 32'(estado), 6);
    chk("g1_barcos_pc", 32'(barcosPCRestantes), 0);
    chk("g1_ganador", 32'(ganador), 1);
    chk("g1_terminado", 32'(juegoTerminado), 1);
    seleccionListo = 1'b1; cantidadBarcosSeleccionada = 3'd2;
    resultadoPC = 1'b1; hundioPC = 1'b1; disparoJugador = 1'b1;
    resultadoJugador = 1'b1; hundioJugador = 1'b1;
    pulse_tick();
    chk("g1_hold_estado", 32'(estado), 6);
    chk("g1_hold_ganador", 32'(ganador), 1);
    chk("g1_hold_barcos_j", 32'(barcosJugadorRestantes), 1);

    // Two-ship game: PC sinks both player ships around player misses.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seleccionListo = 1'b1; cantidadBarcosSeleccionada = 3'd2;
    pulse_tick();
    colocacionListaJugador = 1'b1;
    pulse_tick();
    colocacionListaPC = 1'b1;
    pulse_tick();
    disparoJugador = 1'b1;
    pulse_tick();
    resultadoJugador = 1'b1; hundioJugador = 1'b0;
    pulse_tick();
    chk("g2_sol1", 32'(solicitarDisparoPC), 1);
    chk("g2_barcos_pc", 32'(barcosPCRestantes), 2);
    tick();
    chk("g2_sol1_fin", 32'(solicitarDisparoPC), 0);
    resultadoPC = 1'b1; hundioPC = 1'b1;
    pulse_tick();
    chk("g2_turno_j", 32'(estado), 3);
    chk("g2_barcos_j1", 32'(barcosJugadorRestantes), 1);
    chk("g2_sol_off", 32'(solicitarDisparoPC), 0);
    disparoJugador = 1'b1;
    pulse_tick();
    resultadoJugador = 1'b1; hundioJugador = 1'b0;
    pulse_tick();
    chk("g2_sol2", 32'(solicitarDisparoPC), 1);
    resultadoPC = 1'b1; hundioPC = 1'b1;
    pulse_tick();
    chk("g2_fin", 32'(estado), 6);
    chk("g2_ganador", 32'(ganador), 2);
    chk("g2_barcos_j0", 32'(barcosJugadorRestantes), 0);
    chk("g2_barcos_pc_fin", 32'(barcosPCRestantes), 2);
    chk("g2_terminado", 32'(juegoTerminado), 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("fin_rst_estado", 32'(estado), 0);
    chk("fin_rst_ganador", 32'(ganador), 0);
    chk("fin_rst_barcos", 32'({barcosPCRestantes, barcosJugadorRestantes}), 0);
    chk("fin_rst_seg", 32'(segundosRestantes), 2);
    chk("fin_rst_term", 32'(juegoTerminado), 0);
    chk("fin_rst_sel", 32'(habilitarSeleccion), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controlador_turnos.md
Name: controlador_turnos

Overview:
- Top-level game sequencer for the Battleship board.
- Consumes the ship count chosen by the ship-selection stage, then sequences player placement, PC placement and alternating shot turns.
- Enforces a per-turn player timeout with an automatic shot, tracks remaining ships per side and declares the winner.
- Sits between the selection/placement blocks and the board/shot datapaths; owns which of them is enabled at any cycle.

Parameters:
CLK_HZ, 50_000_000, clock cycles per one-second tick
TURN_SECONDS, 15, player turn length in seconds (1..15)
MAX_SHIPS, 5, largest legal ship count

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
seleccionListo  in  1  ship count confirmed; sampled only in SELECCION
cantidadBarcosSeleccionada  in  3  confirmed ship count
colocacionListaJugador  in  1  pulse: player finished placing ships
colocacionListaPC  in  1  pulse: PC finished placing ships
disparoJugador  in  1  pulse: player committed a shot
resultadoJugador  in  1  pulse: board resolved the player shot
hundioJugador  in  1  qualifier of resultadoJugador: shot sank a PC ship
resultadoPC  in  1  pulse: board resolved the PC shot
hundioPC  in  1  qualifier of resultadoPC: shot sank a player ship
estado  out  3  current state encoding
habilitarSeleccion  out  1  high in SELECCION
habilitarColocacion  out  1  high in COLOC_J
turnoJugador  out  1  high in TURNO_J
solicitarDisparoPC  out  1  one-cycle pulse on entry to TURNO_PC
disparoAutomatico  out  1  one-cycle pulse on player timeout
segundosRestantes  out  4  player turn seconds left
barcosPCRestantes  out  3  PC ships not yet sunk
barcosJugadorRestantes  out  3  player ships not yet sunk
ganador  out  2  00 none, 01 player, 10 PC
juegoTerminado  out  1  high in FIN

Behaviour:
- Reset (synchronous, active-high, wins over all inputs, legal mid-game):
  - state = SELECCION; all pulses 0.
  - segundosRestantes = TURN_SECONDS; both ship counters 0; ganador = 00; prescaler 0.
- States and transitions:
  - SELECCION(0):
    - On seleccionListo with count in 1..MAX_SHIPS: latch count into both ship counters, go to COLOC_J.
    - Count 0 or >MAX_SHIPS: ignored, stay.
  - COLOC_J(1): on colocacionListaJugador -> COLOC_PC.
  - COLOC_PC(2): on colocacionListaPC -> TURNO_J. Load segundosRestantes = TURN_SECONDS and clear the prescaler.
  - TURNO_J(3): prescaler counts 0..CLK_HZ-1; each wrap decrements segundosRestantes.
    - On disparoJugador -> ESPERA_J.
    - If segundosRestantes = 0 and no disparoJugador that cycle: pulse disparoAutomatico for 1 cycle, go to ESPERA_J.
    - disparoJugador and timeout on the same cycle: the shot wins, no automatic pulse.
  - ESPERA_J(4): on resultadoJugador:
    - If hundioJugador, decrement barcosPCRestantes.
    - If the new value is 0: ganador = 01, go to FIN.
    - Otherwise go to TURNO_PC.
  - TURNO_PC(5): solicitarDisparoPC high exactly on the first cycle in state. On resultadoPC:
    - If hundioPC, decrement barcosJugadorRestantes.
    - If the new value is 0: ganador = 10, go to FIN.
    - Otherwise go to TURNO_J with the timer reloaded.
  - FIN(6): hold all counters and ganador until reset.
- Inputs arriving outside their state are ignored, e.g. a stray resultadoPC or disparoJugador during placement.
- Counters never underflow: a decrement at 0 is suppressed.
- All outputs are registered or decoded from the state register; latency from input pulse to state change is 1 cycle.
- Width rules:
  - Prescaler width is $clog2(CLK_HZ).
  - segundosRestantes saturates at 0 and stays 0 until reload.

Decomposition:
- Package juego_pkg:
  - State enum estado_t (SELECCION..FIN, 3 bits).
  - ganador codes.
  - MAX_SHIPS default.
- One sub-module: temporizador_turno.
  - Contents: prescaler plus seconds down-counter.
  - Inputs: cargar, habilitar.
  - Outputs: segundos, expirado.

Test Plan:
- Reset, then seleccionListo with count 0, then with 6 -> stays SELECCION. Count 3 -> COLOC_J next cycle; both ship counters = 3.
- Placement pulses in order -> COLOC_PC then TURNO_J. segundosRestantes = 15; stray resultadoPC during COLOC_J causes no change.
- CLK_HZ=4, TURN_SECONDS=2, no shot:
  - segundosRestantes 2->1->0 at 4-cycle spacing.
  - Then a single disparoAutomatico pulse; state ESPERA_J.
- disparoJugador on the exact timeout cycle -> ESPERA_J, disparoAutomatico stays 0.
- Count 1: player shot, resultadoJugador with hundioJugador=1 -> barcosPCRestantes 0, ganador=01, juegoTerminado=1. Further pulses ignored.
- Count 2:
  - PC sinks twice, with player misses in between -> ganador=10.
  - solicitarDisparoPC pulses once per PC turn.
  - Assert reset in FIN -> all outputs return to reset values next cycle.
